// File: rtl/brc_pred_ctrl.sv
// Branch prediction (direct-mapped BTB, 2-bit counters) and EX-side mispredict
// redirect controller. Redirects are held until IF accepts them; flush pulses once.
module brc_pred_ctrl #(
    parameter int XLEN        = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int TAG_W       = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            if_pred_taken_o,
    output logic [XLEN-1:0] if_pred_pc_o,
    input  logic            ex_valid_i,
    input  logic            ex_stall_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic            ex_is_brc_i,
    input  logic            ex_is_jal_i,
    input  logic            ex_is_jalr_i,
    input  logic            ex_is_jump_i,
    input  logic [XLEN-1:0] ex_brc_pc_i,
    input  logic            ex_pred_taken_i,
    input  logic [XLEN-1:0] ex_pred_pc_i,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            redirect_ready_i,
    output logic            flush_o,
    output logic [31:0]     mispred_cnt_o,
    output logic            dbg_state_o
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);

    typedef enum logic {IDLE = 1'b0, REDIR = 1'b1} state_t;

    state_t state_q, state_d;
    logic            redir_valid_q, redir_valid_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic            flush_q, flush_d;
    logic [31:0]     cnt_q, cnt_d;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_q [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;

    assign if_idx = if_pc_i[IDX_W+1:2];
    assign if_tag = if_pc_i[TAG_W+IDX_W+1:IDX_W+2];
    assign ex_idx = ex_pc_i[IDX_W+1:2];
    assign ex_tag = ex_pc_i[TAG_W+IDX_W+1:IDX_W+2];

    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Fetch-side lookup reads only registered state, so same-cycle writes are not bypassed.
    assign if_pred_taken_o = if_hit && ctr_q[if_idx][1];
    assign if_pred_pc_o    = if_pred_taken_o ? target_q[if_idx] : if_pc_i + XLEN'(4);

    logic            resolve, is_ctrl, taken, mispred;
    logic [XLEN-1:0] actual_pc;

    assign resolve   = ex_valid_i && !ex_stall_i && (state_q == IDLE);
    assign is_ctrl   = ex_is_brc_i || ex_is_jal_i || ex_is_jalr_i;
    assign taken     = ex_is_jal_i || ex_is_jalr_i || (ex_is_brc_i && ex_is_jump_i);
    assign actual_pc = taken ? ex_brc_pc_i : ex_pc_i + XLEN'(4);
    assign mispred   = (taken != ex_pred_taken_i) || (taken && (ex_pred_pc_i != ex_brc_pc_i));

    logic            wr_en, wr_valid;
    logic [TAG_W-1:0] wr_tag;
    logic [XLEN-1:0] wr_target;
    logic [1:0]      wr_ctr;

    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = valid_q[ex_idx];
        wr_tag    = tag_q[ex_idx];
        wr_target = target_q[ex_idx];
        wr_ctr    = ctr_q[ex_idx];
        if (resolve) begin
            if (is_ctrl) begin
                if (ex_hit) begin
                    wr_en = 1'b1;
                    if (taken) begin
                        wr_target = ex_brc_pc_i;
                        if (wr_ctr != 2'd3) wr_ctr = wr_ctr + 2'd1;
                    end else if (wr_ctr != 2'd0) begin
                        wr_ctr = wr_ctr - 2'd1;
                    end
                end else if (taken) begin
                    wr_en     = 1'b1;
                    wr_valid  = 1'b1;
                    wr_tag    = ex_tag;
                    wr_target = ex_brc_pc_i;
                    wr_ctr    = 2'd2;
                end
            end else if (ex_hit) begin
                // A non-branch matching an entry means the entry aliases; drop it.
                wr_en    = 1'b1;
                wr_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'd0;
            end
        end else if (wr_en) begin
            valid_q[ex_idx]  <= wr_valid;
            tag_q[ex_idx]    <= wr_tag;
            target_q[ex_idx] <= wr_target;
            ctr_q[ex_idx]    <= wr_ctr;
        end
    end

    always_comb begin
        state_d       = state_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        flush_d       = 1'b0;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (resolve && mispred) begin
                    state_d       = REDIR;
                    redir_valid_d = 1'b1;
                    redir_pc_d    = actual_pc;
                    flush_d       = 1'b1;
                    cnt_d         = cnt_q + 32'd1;
                end
            end
            REDIR: begin
                if (redirect_ready_i) begin
                    state_d       = IDLE;
                    redir_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            flush_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            flush_q       <= flush_d;
            cnt_q         <= cnt_d;
        end
    end

    assign redirect_valid_o = redir_valid_q;
    assign redirect_pc_o    = redir_pc_q;
    assign flush_o          = flush_q;
    assign mispred_cnt_o    = cnt_q;
    assign dbg_state_o      = state_q;

endmodule
